traffic_density_sensor: RTL and testbench

Upstream stage of the traffic-light `controller`. It turns the raw loop-detector inputs of the three roads into the per-road density flags `L[2:0]` / `H[2:0]` that the controller uses to pick its phase sequence. For each road it synchronises and debounces the detector, counts vehicle arrivals over a fixed sampling window, and classifies the count with hysteresis. The flags are registered and held for a full window, so the controller always sees stable values.

---
 rtl/traffic_density_sensor.sv | 109 ++++++++++
 tb/tb_traffic_density_sensor.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_density_sensor.sv
// Three-lane loop-detector front end: synchronise, debounce, count arrivals per
// sampling window and classify each road as light/heavy with heavy-release hysteresis.
module traffic_density_sensor #(
    parameter int WINDOW  = 1000,
    parameter int DEB     = 4,
    parameter int CW      = 8,
    parameter int LOW_TH  = 2,
    parameter int HIGH_TH = 5,
    parameter int HYST    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] det,
    output logic [2:0] L,
    output logic [2:0] H,
    output logic       valid,
    output logic [2:0] sat
);

    localparam int WCW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int DCW = (DEB > 1) ? $clog2(DEB) : 1;

    localparam logic [WCW-1:0] WC_LAST = WCW'(WINDOW - 1);
    localparam logic [DCW-1:0] DC_LAST = DCW'(DEB - 1);
    localparam logic [CW-1:0]  VC_MAX  = '1;
    localparam logic [CW-1:0]  TH_LOW  = CW'(LOW_TH);
    localparam logic [CW-1:0]  TH_HIGH = CW'(HIGH_TH);
    localparam logic [CW-1:0]  TH_KEEP = CW'(HIGH_TH - HYST);

    logic [2:0]     r_s1;
    logic [2:0]     r_s;
    logic [2:0]     r_lvl;
    logic [2:0]     r_sat_w;
    logic [DCW-1:0] r_dc [3];
    logic [CW-1:0]  r_vc [3];
    logic [WCW-1:0] r_wc;

    logic           w_close;
    logic [2:0]     w_rise;
    logic [2:0]     w_sat_now;
    logic [2:0]     w_h_new;
    logic [2:0]     w_l_new;
    logic [CW-1:0]  w_n [3];

    // w_n is the count including an arrival on this very edge, so a rise that
    // coincides with the window close is classified in the closing window.
    always_comb begin
        w_close = (r_wc == WC_LAST);
        for (int unsigned i = 0; i < 3; i++) begin
            w_rise[i]    = r_s[i] && !r_lvl[i] && (r_dc[i] == DC_LAST);
            w_sat_now[i] = w_rise[i] && (r_vc[i] == VC_MAX);
            w_n[i]       = (w_rise[i] && !w_sat_now[i]) ? r_vc[i] + CW'(1) : r_vc[i];
            w_h_new[i]   = (w_n[i] >= TH_HIGH) || (H[i] && (w_n[i] >= TH_KEEP));
            w_l_new[i]   = !w_h_new[i] && (w_n[i] >= TH_LOW);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1    <= '0;
            r_s     <= '0;
            r_lvl   <= '0;
            r_sat_w <= '0;
            r_wc    <= '0;
            L       <= '0;
            H       <= '0;
            sat     <= '0;
            valid   <= 1'b0;
            for (int unsigned i = 0; i < 3; i++) begin
                r_dc[i] <= '0;
                r_vc[i] <= '0;
            end
        end else begin
            r_s1 <= det;
            r_s  <= r_s1;

            for (int unsigned i = 0; i < 3; i++) begin
                if (r_s[i] == r_lvl[i]) begin
                    r_dc[i] <= '0;
                end else if (r_dc[i] == DC_LAST) begin
                    r_lvl[i] <= r_s[i];
                    r_dc[i]  <= '0;
                end else begin
                    r_dc[i] <= r_dc[i] + DCW'(1);
                end
            end

            if (w_close) begin
                r_wc    <= '0;
                H       <= w_h_new;
                L       <= w_l_new;
                sat     <= r_sat_w | w_sat_now;
                valid   <= 1'b1;
                r_sat_w <= '0;
                for (int unsigned i = 0; i < 3; i++) begin
                    r_vc[i] <= '0;
                end
            end else begin
                r_wc    <= r_wc + WCW'(1);
                valid   <= 1'b0;
                r_sat_w <= r_sat_w | w_sat_now;
                for (int unsigned i = 0; i < 3; i++) begin
                    r_vc[i] <= w_n[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_traffic_density_sensor.sv
// Bench for traffic_density_sensor: per-window vector table, hand-written boundary
// sequence and a randomized phase, all cross-checked cycle by cycle against a reference model.
module tb_traffic_density_sensor;

    localparam int WINDOW  = 100;
    localparam int DEB     = 4;
    localparam int CW      = 3;
    localparam int LOW_TH  = 2;
    localparam int HIGH_TH = 5;
    localparam int HYST    = 2;
    localparam int VMAX    = (1 << CW) - 1;

    logic       clk;
    logic       reset;
    logic [2:0] det;
    logic [2:0] L;
    logic [2:0] H;
    logic       valid;
    logic [2:0] sat;

    int checks   = 0;
    int failures = 0;

    traffic_density_sensor #(
        .WINDOW (WINDOW),
        .DEB    (DEB),
        .CW     (CW),
        .LOW_TH (LOW_TH),
        .HIGH_TH(HIGH_TH),
        .HYST   (HYST)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .det  (det),
        .L    (L),
        .H    (H),
        .valid(valid),
        .sat  (sat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each road keeps the raw detector samples since reset in a short queue: the
    // two newest are still in the synchroniser, the older DEB are what the
    // debouncer has seen. The level flips once all DEB seen samples disagree with it.
    bit         m_on = 1'b0;
    int         m_age;
    int         m_cnt [3];
    bit         m_lvl [3];
    bit         m_q   [3][$];
    logic [2:0] m_L, m_H, m_sat;
    logic       m_valid;

    task automatic model_step();
        bit all1, all0, close, hnew;
        int n;
        if (reset) begin
            m_on    = 1'b1;
            m_age   = 0;
            m_L     = '0;
            m_H     = '0;
            m_sat   = '0;
            m_valid = 1'b0;
            for (int i = 0; i < 3; i++) begin
                m_cnt[i] = 0;
                m_lvl[i] = 1'b0;
                m_q[i].delete();
                repeat (DEB + 2) m_q[i].push_back(1'b0);
            end
        end else if (m_on) begin
            close = ((m_age % WINDOW) == WINDOW - 1);
            for (int i = 0; i < 3; i++) begin
                m_q[i].push_back(det[i]);
                void'(m_q[i].pop_front());
                all1 = 1'b1;
                all0 = 1'b1;
                for (int j = 0; j < DEB; j++) begin
                    if (m_q[i][j]) all0 = 1'b0;
                    else           all1 = 1'b0;
                end
                if (!m_lvl[i] && all1) begin
                    m_lvl[i] = 1'b1;
                    m_cnt[i]++;
                end else if (m_lvl[i] && all0) begin
                    m_lvl[i] = 1'b0;
                end
            end
            m_valid = close;
            if (close) begin
                for (int i = 0; i < 3; i++) begin
                    n        = (m_cnt[i] > VMAX) ? VMAX : m_cnt[i];
                    hnew     = (n >= HIGH_TH) || (m_H[i] && (n >= HIGH_TH - HYST));
                    m_H[i]   = hnew;
                    m_L[i]   = !hnew && (n >= LOW_TH);
                    m_sat[i] = (m_cnt[i] > VMAX);
                    m_cnt[i] = 0;
                end
            end
            m_age++;
        end
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (m_on) begin
            check("model_valid", 32'(valid), 32'(m_valid));
            check("model_L",     32'(L),     32'(m_L));
            check("model_H",     32'(H),     32'(m_H));
            check("model_sat",   32'(sat),   32'(m_sat));
        end
    end

    // ---------------- directed helpers ----------------
    typedef struct {
        string      name;
        int         c0, c1, c2;
        int         hi, gap;
        logic [2:0] exp_l, exp_h, exp_sat;
    } row_t;

    task automatic skip(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_row(input int c0, input int c1, input int c2, input int hi, input int gap);
        int cmax;
        cmax = (c0 > c1) ? c0 : c1;
        cmax = (c2 > cmax) ? c2 : cmax;
        for (int k = 0; k < cmax; k++) begin
            det = {(k < c2), (k < c1), (k < c0)};
            skip(hi);
            det = '0;
            skip(gap);
        end
        det = '0;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (valid !== 1'b1 && n < 3 * WINDOW) begin
            @(negedge clk);
            n++;
        end
        if (valid !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL %s: valid not seen within %0d cycles", name, 3 * WINDOW);
        end
    endtask

    task automatic check_flags(input string name, input logic [2:0] el, input logic [2:0] eh,
                               input logic [2:0] es);
        check({name, "_valid"}, 32'(valid), 32'd1);
        check({name, "_L"},     32'(L),     32'(el));
        check({name, "_H"},     32'(H),     32'(eh));
        check({name, "_sat"},   32'(sat),   32'(es));
        skip(1);
        check({name, "_valid_1cyc"}, 32'(valid), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    row_t rows [10];
    int   waited;
    int   hold [3];
    int   maxh [3];

    initial begin
        rows[0] = '{"debounce_3cyc",  10, 0, 0, 3, 4, 3'b000, 3'b000, 3'b000};
        rows[1] = '{"debounce_4cyc",   3, 0, 0, 4, 4, 3'b001, 3'b000, 3'b000};
        rows[2] = '{"classify",        1, 3, 6, 4, 4, 3'b010, 3'b100, 3'b000};
        rows[3] = '{"hyst_keep",       0, 0, 3, 4, 4, 3'b000, 3'b100, 3'b000};
        rows[4] = '{"hyst_release",    0, 0, 2, 4, 4, 3'b100, 3'b000, 3'b000};
        rows[5] = '{"saturate",        0, 9, 0, 4, 4, 3'b000, 3'b010, 3'b010};
        rows[6] = '{"sat_clear",       0, 0, 0, 4, 4, 3'b000, 3'b000, 3'b000};
        rows[7] = '{"mixed",           2, 5, 4, 5, 4, 3'b101, 3'b010, 3'b000};
        rows[8] = '{"mixed_keep",      0, 4, 4, 4, 4, 3'b100, 3'b010, 3'b000};
        rows[9] = '{"short_gap_merge", 3, 0, 0, 4, 3, 3'b000, 3'b000, 3'b000};

        // Reset with all detectors held high: two reset edges, then release.
        reset = 1'b1;
        det   = 3'b111;
        skip(2);
        reset = 1'b0;

        // Held detectors rise once each after release; window closes WINDOW edges after the last reset edge.
        waited = 0;
        while (valid !== 1'b1 && waited < 3 * WINDOW) begin
            @(negedge clk);
            waited++;
            if (waited == 20) det = '0;
        end
        check("reset_first_valid_delay", 32'(waited), 32'(WINDOW));
        check_flags("reset_window", 3'b000, 3'b000, 3'b000);

        for (int r = 0; r < 10; r++) begin
            drive_row(rows[r].c0, rows[r].c1, rows[r].c2, rows[r].hi, rows[r].gap);
            wait_valid(rows[r].name);
            check_flags(rows[r].name, rows[r].exp_l, rows[r].exp_h, rows[r].exp_sat);
        end

        // Boundary: one early arrival, then a level rise landing exactly on the closing edge.
        det = 3'b001;
        skip(4);
        det = '0;
        skip(89);
        det = 3'b001;
        skip(6);
        check_flags("boundary_close", 3'b001, 3'b000, 3'b000);
        skip(1);
        det = '0;
        skip(8);
        // One more arrival: a fresh window gives n=1 (none); a leaked boundary arrival would give light.
        det = 3'b001;
        skip(5);
        det = '0;
        wait_valid("boundary_next");
        check_flags("boundary_next", 3'b000, 3'b000, 3'b000);

        // Randomized detector activity with a mid-run reset, checked by the model.
        for (int i = 0; i < 3; i++) begin
            hold[i] = 0;
            maxh[i] = 4;
        end
        for (int cyc = 0; cyc < 2400; cyc++) begin
            if (cyc % 150 == 0) begin
                for (int i = 0; i < 3; i++) maxh[i] = int'($urandom_range(30, 2));
            end
            if (cyc == 1234) reset = 1'b1;
            if (cyc == 1236) reset = 1'b0;
            for (int i = 0; i < 3; i++) begin
                if (hold[i] == 0) begin
                    det[i]  = ~det[i];
                    hold[i] = int'($urandom_range(maxh[i], 1));
                end else begin
                    hold[i]--;
                end
            end
            @(negedge clk);
        end
        det = '0;
        skip(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        failures++;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
